// File: rtl/fifo_pkg.sv
// Shared types and helpers for the sync_fifo_gen2 family.
package fifo_pkg;

    // Read-side presentation mode.
    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // Occupancy flags, decoded from the count.
    typedef struct packed {
        logic full;
        logic empty;
        logic almostfull;
        logic almostempty;
    } fifo_flags_t;

    localparam fifo_flags_t FIFO_FLAGS_RST = '{
        full:        1'b0,
        empty:       1'b1,
        almostfull:  1'b0,
        almostempty: 1'b0
    };

    // Width of a counter that must hold 0..depth inclusive.
    function automatic int unsigned fifo_cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_fifo_gen2_if.sv
// Producer/consumer bus of sync_fifo_gen2.
interface sync_fifo_gen2_if
    import fifo_pkg::*;
#(
    parameter int unsigned FIFO_WIDTH = 16,
    parameter int unsigned CNT_W      = fifo_cnt_w(8)
);
    logic [FIFO_WIDTH-1:0] data_in;
    logic                  wr_en;
    logic                  rd_en;
    logic [FIFO_WIDTH-1:0] data_out;
    logic                  wr_ack;
    logic                  overflow;
    logic                  underflow;
    logic                  full;
    logic                  empty;
    logic                  almostfull;
    logic                  almostempty;
    logic [CNT_W-1:0]      count;

    // Producer/consumer side.
    modport master (
        output data_in, wr_en, rd_en,
        input  data_out, wr_ack, overflow, underflow,
        input  full, empty, almostfull, almostempty, count
    );

    // FIFO side.
    modport slave (
        input  data_in, wr_en, rd_en,
        output data_out, wr_ack, overflow, underflow,
        output full, empty, almostfull, almostempty, count
    );
endinterface

// File: rtl/fifo_mem.sv
// 1-write/1-read storage array: synchronous write, combinational read, no reset.
module fifo_mem #(
    parameter  int unsigned WIDTH = 16,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata_c
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_c = mem[raddr];
endmodule

// File: rtl/sync_fifo_gen2.sv
// Parametrised single-clock FIFO: arbitrary depth, thresholds, count, STD/FWFT read.
// Optional feature macro: FIFO_FLUSH_EN adds a synchronous flush input.
module sync_fifo_gen2
    import fifo_pkg::*;
#(
    parameter int unsigned FIFO_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned AF_THRESH  = FIFO_DEPTH - 1,
    parameter int unsigned AE_THRESH  = 1,
    parameter fifo_mode_e  MODE       = FIFO_STD
) (
    input logic clk,
    input logic rst_n,
`ifdef FIFO_FLUSH_EN
    input logic flush,
`endif
    sync_fifo_gen2_if.slave bus
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = fifo_cnt_w(FIFO_DEPTH);

    // Elaboration-time parameter legality.
    if (FIFO_WIDTH < 1) begin : g_bad_width
        $error("sync_fifo_gen2: FIFO_WIDTH must be >= 1");
    end
    if (FIFO_DEPTH < 2) begin : g_bad_depth
        $error("sync_fifo_gen2: FIFO_DEPTH must be >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > FIFO_DEPTH - 1) begin : g_bad_af
        $error("sync_fifo_gen2: AF_THRESH must be in 1..FIFO_DEPTH-1");
    end
    if (AE_THRESH < 1 || AE_THRESH > FIFO_DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo_gen2: AE_THRESH must be in 1..FIFO_DEPTH-1");
    end

    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    fifo_flags_t           flags;
    logic                  wr_ack;
    logic                  overflow;
    logic                  underflow;
    logic [FIFO_WIDTH-1:0] rdata_c;

    logic                  clear_c;
    logic                  wr_acc_c;
    logic                  rd_acc_c;
    logic [CW-1:0]         count_nxt_c;
    fifo_flags_t           flags_nxt_c;

`ifdef FIFO_FLUSH_EN
    assign clear_c = flush;
`else
    assign clear_c = 1'b0;
`endif

    // Pointer advance with explicit wrap at the last entry.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Accept decisions, next occupancy and its flag decode.
    always_comb begin
        wr_acc_c    = bus.wr_en && !flags.full  && !clear_c;
        rd_acc_c    = bus.rd_en && !flags.empty && !clear_c;
        count_nxt_c = count;
        if (clear_c) begin
            count_nxt_c = '0;
        end else if (wr_acc_c && !rd_acc_c) begin
            count_nxt_c = count + CW'(1);
        end else if (rd_acc_c && !wr_acc_c) begin
            count_nxt_c = count - CW'(1);
        end
        flags_nxt_c             = FIFO_FLAGS_RST;
        flags_nxt_c.full        = (count_nxt_c == CW'(FIFO_DEPTH));
        flags_nxt_c.empty       = (count_nxt_c == '0);
        flags_nxt_c.almostfull  = (count_nxt_c >= CW'(AF_THRESH)) && !flags_nxt_c.full;
        flags_nxt_c.almostempty = (count_nxt_c != '0) && (count_nxt_c <= CW'(AE_THRESH));
    end

    // Pointers, occupancy, flags and one-shot handshake status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            flags     <= FIFO_FLAGS_RST;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (clear_c) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_acc_c) wr_ptr <= ptr_inc(wr_ptr);
                if (rd_acc_c) rd_ptr <= ptr_inc(rd_ptr);
            end
            count     <= count_nxt_c;
            flags     <= flags_nxt_c;
            wr_ack    <= wr_acc_c;
            overflow  <= bus.wr_en && flags.full  && !clear_c;
            underflow <= bus.rd_en && flags.empty && !clear_c;
        end
    end

    fifo_mem #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_mem (
        .clk     (clk),
        .we      (wr_acc_c),
        .waddr   (wr_ptr),
        .wdata   (bus.data_in),
        .raddr   (rd_ptr),
        .rdata_c (rdata_c)
    );

    if (MODE == FIFO_FWFT) begin : g_fwft
        // Head word presented directly; forced to zero while empty so reset reads 0.
        assign bus.data_out = flags.empty ? '0 : rdata_c;
    end else begin : g_std
        logic [FIFO_WIDTH-1:0] dout_q;

        // Output register loads the head on an accepted read, otherwise holds.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dout_q <= '0;
            end else if (rd_acc_c) begin
                dout_q <= rdata_c;
            end
        end

        assign bus.data_out = dout_q;
    end

    assign bus.wr_ack      = wr_ack;
    assign bus.overflow    = overflow;
    assign bus.underflow   = underflow;
    assign bus.full        = flags.full;
    assign bus.empty       = flags.empty;
    assign bus.almostfull  = flags.almostfull;
    assign bus.almostempty = flags.almostempty;
    assign bus.count       = count;
endmodule

// File: tb/tb_sync_fifo_gen2.sv
// Randomised + directed bench for sync_fifo_gen2 against a queue-based model.
// Three instances share one stimulus: u0 depth 8 STD, u1 depth 6 STD (AF 4, AE 2),
// u2 depth 5 FWFT (AF 3, AE 2).
module tb_sync_fifo_gen2;
    import fifo_pkg::*;

    localparam int unsigned W = 16;
    localparam int          N = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         wr_en;
    logic         rd_en;
    logic         flush;
    logic [W-1:0] data_in;

    always #5 clk = ~clk;

    sync_fifo_gen2_if #(.FIFO_WIDTH(W), .CNT_W(fifo_cnt_w(8))) bus0 ();
    sync_fifo_gen2_if #(.FIFO_WIDTH(W), .CNT_W(fifo_cnt_w(6))) bus1 ();
    sync_fifo_gen2_if #(.FIFO_WIDTH(W), .CNT_W(fifo_cnt_w(5))) bus2 ();

    assign bus0.data_in = data_in;
    assign bus0.wr_en   = wr_en;
    assign bus0.rd_en   = rd_en;
    assign bus1.data_in = data_in;
    assign bus1.wr_en   = wr_en;
    assign bus1.rd_en   = rd_en;
    assign bus2.data_in = data_in;
    assign bus2.wr_en   = wr_en;
    assign bus2.rd_en   = rd_en;

    sync_fifo_gen2 #(.FIFO_WIDTH(W), .FIFO_DEPTH(8)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef FIFO_FLUSH_EN
        .flush (flush),
`endif
        .bus   (bus0)
    );

    sync_fifo_gen2 #(.FIFO_WIDTH(W), .FIFO_DEPTH(6), .AF_THRESH(4), .AE_THRESH(2),
                     .MODE(FIFO_STD)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef FIFO_FLUSH_EN
        .flush (flush),
`endif
        .bus   (bus1)
    );

    sync_fifo_gen2 #(.FIFO_WIDTH(W), .FIFO_DEPTH(5), .AF_THRESH(3), .AE_THRESH(2),
                     .MODE(FIFO_FWFT)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef FIFO_FLUSH_EN
        .flush (flush),
`endif
        .bus   (bus2)
    );

    // Model state: queue contents plus the registered one-shot outputs.
    logic [W-1:0] mq [N][$];
    logic         m_ack  [N];
    logic         m_ovf  [N];
    logic         m_udf  [N];
    logic [W-1:0] m_dout [N];

    int vectors    = 0;
    int miscompares = 0;
    int k          = 0;
    int phase      = 0;
    bit in_rst     = 1'b0;

    function automatic int depth_of(input int i);
        case (i)
            0:       return 8;
            1:       return 6;
            default: return 5;
        endcase
    endfunction

    function automatic int af_of(input int i);
        case (i)
            0:       return 7;
            1:       return 4;
            default: return 3;
        endcase
    endfunction

    function automatic int ae_of(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    function automatic bit is_fwft(input int i);
        return i == 2;
    endfunction

    task automatic chk(input string name, input int i, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s[u%0d] at %0t: got 0x%0h, expected 0x%0h", name, i, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mq[i].delete();
            m_ack[i]  = 1'b0;
            m_ovf[i]  = 1'b0;
            m_udf[i]  = 1'b0;
            m_dout[i] = '0;
        end
    endtask

    // Apply the inputs that the coming rising edge will sample.
    task automatic model_step(input int i);
        int           sz;
        bit           f;
        bit           e;
        bit           wa;
        bit           ra;
        logic [W-1:0] hd;
        sz = mq[i].size();
        f  = (sz == depth_of(i));
        e  = (sz == 0);
        if (flush) begin
            mq[i].delete();
            m_ack[i] = 1'b0;
            m_ovf[i] = 1'b0;
            m_udf[i] = 1'b0;
        end else begin
            wa = wr_en && !f;
            ra = rd_en && !e;
            if (ra) begin
                hd = mq[i].pop_front();
                if (!is_fwft(i)) m_dout[i] = hd;
            end
            if (wa) mq[i].push_back(data_in);
            m_ack[i] = wa;
            m_ovf[i] = wr_en && f;
            m_udf[i] = rd_en && e;
        end
    endtask

    task automatic check_one(input int i, input bit rst, input int cnt,
                             input logic f, input logic e, input logic af, input logic ae,
                             input logic ack, input logic ovf, input logic udf,
                             input logic [W-1:0] dout);
        int sz;
        int d;
        sz = mq[i].size();
        d  = depth_of(i);
        if (rst) begin
            chk("rst_count", i, cnt, 0);
            chk("rst_full", i, int'(f), 0);
            chk("rst_empty", i, int'(e), 1);
            chk("rst_almostfull", i, int'(af), 0);
            chk("rst_almostempty", i, int'(ae), 0);
            chk("rst_wr_ack", i, int'(ack), 0);
            chk("rst_overflow", i, int'(ovf), 0);
            chk("rst_underflow", i, int'(udf), 0);
            chk("rst_data_out", i, int'(dout), 0);
        end else begin
            chk("count", i, cnt, sz);
            chk("full", i, int'(f), int'(sz == d));
            chk("empty", i, int'(e), int'(sz == 0));
            chk("almostfull", i, int'(af), int'(sz >= af_of(i) && sz < d));
            chk("almostempty", i, int'(ae), int'(sz > 0 && sz <= ae_of(i)));
            chk("wr_ack", i, int'(ack), int'(m_ack[i]));
            chk("overflow", i, int'(ovf), int'(m_ovf[i]));
            chk("underflow", i, int'(udf), int'(m_udf[i]));
            if (is_fwft(i)) begin
                if (sz > 0) chk("data_out", i, int'(dout), int'(mq[i][0]));
            end else begin
                chk("data_out", i, int'(dout), int'(m_dout[i]));
            end
        end
    endtask

    task automatic check_all(input bit rst);
        check_one(0, rst, int'(bus0.count), bus0.full, bus0.empty, bus0.almostfull,
                  bus0.almostempty, bus0.wr_ack, bus0.overflow, bus0.underflow, bus0.data_out);
        check_one(1, rst, int'(bus1.count), bus1.full, bus1.empty, bus1.almostfull,
                  bus1.almostempty, bus1.wr_ack, bus1.overflow, bus1.underflow, bus1.data_out);
        check_one(2, rst, int'(bus2.count), bus2.full, bus2.empty, bus2.almostfull,
                  bus2.almostempty, bus2.wr_ack, bus2.overflow, bus2.underflow, bus2.data_out);
    endtask

    // Hand-derived model states along the directed prefix (k = ticks since reset).
    task automatic pin_model();
        case (k)
            1: begin
                chk("pin_fwft_size", 2, mq[2].size(), 1);
                if (mq[2].size() > 0) chk("pin_fwft_head", 2, int'(mq[2][0]), 'hA001);
            end
            2:  chk("pin_size_k2", 1, mq[1].size(), 2);
            6:  chk("pin_size_k6", 1, mq[1].size(), 6);
            8: begin
                chk("pin_fill_size", 0, mq[0].size(), 8);
                chk("pin_fill_ack", 0, int'(m_ack[0]), 1);
            end
            9: begin
                chk("pin_ovf", 0, int'(m_ovf[0]), 1);
                chk("pin_ovf_size", 0, mq[0].size(), 8);
            end
            10: chk("pin_first_read", 0, int'(m_dout[0]), 'hA001);
            15: chk("pin_d6_last_read", 1, int'(m_dout[1]), 'hA006);
            17: begin
                chk("pin_last_read", 0, int'(m_dout[0]), 'hA008);
                chk("pin_drained", 0, mq[0].size(), 0);
            end
            18: begin
                chk("pin_udf", 0, int'(m_udf[0]), 1);
                chk("pin_udf_hold", 0, int'(m_dout[0]), 'hA008);
            end
            22: chk("pin_both_mid", 0, mq[0].size(), 3);
            28: begin
                chk("pin_both_full_size", 0, mq[0].size(), 7);
                chk("pin_both_full_ovf", 0, int'(m_ovf[0]), 1);
            end
            36: begin
                chk("pin_both_empty_size", 0, mq[0].size(), 1);
                chk("pin_both_empty_udf", 0, int'(m_udf[0]), 1);
                chk("pin_both_empty_ack", 0, int'(m_ack[0]), 1);
            end
            default: ;
        endcase
    endtask

    // Compare process: 1 time unit after each falling edge, or right after reset asserts.
    always begin
        @(negedge clk or negedge rst_n);
        #1;
        if (!rst_n) begin
            if (!in_rst && phase == 2) chk("pin_midburst_size", 0, mq[0].size(), 5);
            in_rst = 1'b1;
            model_reset();
            check_all(1'b1);
        end else begin
            in_rst = 1'b0;
            check_all(1'b0);
            pin_model();
            for (int i = 0; i < N; i++) model_step(i);
            k++;
        end
    end

    task automatic tick(input logic w, input logic r, input logic [W-1:0] d);
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse, asserted mid-cycle; release lands between edges.
    task automatic reset_pulse();
        #2;
        rst_n = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pw;
        int pr;
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        flush   = 1'b0;
        data_in = '0;
        #22;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill past full, then drain past empty.
        for (int n = 1; n <= 9; n++) tick(1'b1, 1'b0, W'(16'hA000 + n));
        for (int n = 0; n < 9; n++) tick(1'b0, 1'b1, '0);

        // Simultaneous read+write at mid occupancy, at full, at empty.
        for (int n = 1; n <= 3; n++) tick(1'b1, 1'b0, W'(16'hB000 + n));
        tick(1'b1, 1'b1, 16'hB004);
        for (int n = 5; n <= 9; n++) tick(1'b1, 1'b0, W'(16'hB000 + n));
        tick(1'b1, 1'b1, 16'hB00A);
        for (int n = 0; n < 7; n++) tick(1'b0, 1'b1, '0);
        tick(1'b1, 1'b1, 16'hB00B);

        // Stream 24 words through the depth-6 instance in blocks of 6.
        for (int rep = 0; rep < 4; rep++) begin
            for (int n = 0; n < 6; n++) tick(1'b1, 1'b0, W'(16'hC000 + rep * 6 + n));
            for (int n = 0; n < 6; n++) tick(1'b0, 1'b1, '0);
        end

        // Random traffic with a fresh write/read bias every 100 ticks.
        pw = 50;
        pr = 50;
        for (int n = 0; n < 1500; n++) begin
            if (n % 100 == 0) begin
                pw = int'($urandom_range(90, 10));
                pr = int'($urandom_range(90, 10));
            end
`ifdef FIFO_FLUSH_EN
            flush = ($urandom_range(39, 0) == 0);
`endif
            tick(int'($urandom_range(99, 0)) < pw, int'($urandom_range(99, 0)) < pr,
                 W'($urandom));
        end
        flush = 1'b0;

`ifdef FIFO_FLUSH_EN
        // Flush at occupancy 5 overrides a simultaneous write and read.
        reset_pulse();
        for (int n = 0; n < 5; n++) tick(1'b1, 1'b0, W'(16'hD000 + n));
        flush = 1'b1;
        tick(1'b1, 1'b1, 16'hD0FF);
        flush = 1'b0;
        tick(1'b0, 1'b0, '0);
        tick(1'b0, 1'b1, '0);
`endif

        // Reset asserted mid-burst at occupancy 5, then a read on the empty FIFO.
        reset_pulse();
        for (int n = 0; n < 5; n++) tick(1'b1, 1'b0, W'(16'hE000 + n));
        wr_en   = 1'b1;
        data_in = 16'hE0FF;
        phase   = 2;
        reset_pulse();
        phase = 0;
        tick(1'b0, 1'b1, '0);
        tick(1'b0, 1'b0, '0);
        tick(1'b0, 1'b0, '0);
        tick(1'b0, 1'b0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sync_fifo_gen2.md
Name: sync_fifo_gen2

Overview:
Parametrised single-clock FIFO, successor to the fixed 16x8 synchronous FIFO.
- Adds arbitrary (non-power-of-2) depth, programmable almost-full/almost-empty thresholds, an occupancy count output and a first-word-fall-through (FWFT) read mode.
- Sits between any producer/consumer pair in one clock domain; the port list is a superset of the existing FIFO interface signal set.

Parameters:
FIFO_WIDTH, 16, data word width in bits (>=1)
FIFO_DEPTH, 8, number of entries (>=2, any integer)
AF_THRESH, FIFO_DEPTH-1, almostfull asserts when count >= AF_THRESH and not full (1..FIFO_DEPTH-1)
AE_THRESH, 1, almostempty asserts when 0 < count <= AE_THRESH (1..FIFO_DEPTH-1)
MODE, FIFO_STD, fifo_mode_e: FIFO_STD (registered read) or FIFO_FWFT (head word always presented)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
data_in  input  FIFO_WIDTH  write data
wr_en  input  1  write request
rd_en  input  1  read request (FIFO_STD) / pop acknowledge (FIFO_FWFT)
data_out  output  FIFO_WIDTH  read data
wr_ack  output  1  registered: previous cycle's write was accepted
overflow  output  1  registered: previous cycle's write was rejected (full)
underflow  output  1  registered: previous cycle's read was rejected (empty)
full  output  1  count == FIFO_DEPTH
empty  output  1  count == 0
almostfull  output  1  see AF_THRESH
almostempty  output  1  see AE_THRESH
count  output  $clog2(FIFO_DEPTH+1)  current occupancy

Behaviour:
- Reset (async assert, sync release): pointers=0, count=0, data_out=0, wr_ack=0, overflow=0, underflow=0, full=0, empty=1, almostfull=0, almostempty=0. Memory contents are not reset. Reset mid-operation discards all stored data immediately.
- Accept rules (evaluated on current-cycle state):
  - write accepted = wr_en && !full.
  - read accepted = rd_en && !empty.
  - Full with wr_en&&rd_en: read only, overflow=1 next cycle.
  - Empty with wr_en&&rd_en: write only, underflow=1 next cycle.
  - Otherwise both are accepted together and count is unchanged.
- count: +1 on write-only, -1 on read-only, unchanged on both/neither. All flags are combinational decodes of count.
- Pointers wrap explicitly from FIFO_DEPTH-1 to 0. No power-of-2 assumption; no extra-bit pointer compare.
- wr_ack/overflow/underflow: registered, valid one cycle after the request, cleared the following cycle unless re-triggered.
- FIFO_STD: data_out loads mem[rd_ptr] on the edge where a read is accepted (1-cycle latency), otherwise holds. A rejected read leaves data_out unchanged.
- FIFO_FWFT: data_out = mem[rd_ptr] whenever !empty (0 latency). A write into an empty FIFO is visible on data_out the cycle after the write edge. Value is don't-care when empty. rd_en pops the head.
- Illegal parameter combinations (DEPTH<2, thresholds out of range) trigger an elaboration $error.

Optional Feature:
FIFO_FLUSH_EN
- Defined: adds input port flush (1 bit, synchronous).
  - When flush=1 at a clock edge: pointers and count return to 0; wr_en/rd_en are ignored that cycle.
  - wr_ack/overflow/underflow are 0 next cycle; data_out holds its value.
  - flush has priority over all accepts.
- Undefined: no flush port; the only clear is rst_n.

Decomposition:
- Shared package fifo_pkg holds:
  - typedef enum fifo_mode_e {FIFO_STD, FIFO_FWFT}
  - function fifo_cnt_w(depth) returning $clog2(depth+1)
- Natural sub-module fifo_mem: 1-write/1-read storage array with combinational read address and no reset. Pointers, count, flags and the output register stay in sync_fifo_gen2.

Test Plan:
- DEPTH=8, STD: write 0xA001..0xA008 -> full=1, count=8, wr_ack high each following cycle; a 9th write gives overflow=1 and count stays 8.
- STD: 8 reads after fill -> data_out 0xA001..0xA008, each 1 cycle after its rd_en; a 9th read gives underflow=1 and data_out holds 0xA008.
- DEPTH=6, AF_THRESH=4, AE_THRESH=2: step count 0..6 -> almostempty at 1,2; almostfull at 4,5; full at 6; empty at 0. Drain 24 words through 4 wrap cycles in order.
- Simultaneous wr+rd:
  - At count=3: count stays 3.
  - At full: read only, overflow=1.
  - At empty: write only, underflow=1, count=1.
- FWFT: write 0x1234 into empty -> data_out=0x1234 with empty=0 the next cycle, before any rd_en. rd_en then gives empty=1.
- Assert rst_n=0 mid-burst at count=5 -> all outputs take reset values asynchronously. After release, a read gives underflow=1. With FIFO_FLUSH_EN: flush at count=5 -> count=0 and empty=1 next cycle.
